inlinewrite_control: RTL and testbench

- Write-side counterpart of the line-buffer read controller: takes one line of feature data as a valid/ready stream and writes it into the BUFFER_NUM dual-port line-buffer banks through port A (addra/dina/wea).
- Optionally brackets the line with zero pad words, so the read side sees the same line length with or without padding.
- Sits between the input DMA/FIFO and the line-buffer RAM array; one line per configuration handshake.

---
 rtl/inlinewrite_control.sv | 194 +++++++++++++++++++
 tb/tb_inlinewrite_control.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inlinewrite_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inlinewrite_control                                                        |
// | Writes one streamed feature line into the line-buffer banks of one mesh    |
// | row, optionally bracketed by zero pad words. Optional wrap check:          |
// | INLINEWRITE_ADDR_CHECK_EN.                                                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module inlinewrite_control #(
  parameter int X_MAC        = 4,
  parameter int X_MESH       = 16,
  parameter int ADDR_LEN     = 13,
  parameter int DATA_LEN     = 32,
  parameter int MAX_LINE_LEN = 10,
  parameter int MESH_SEL_LEN = 4,
  parameter int BUFFER_NUM   = X_MAC * X_MESH,
  parameter int DATAWIDTH    = BUFFER_NUM * DATA_LEN,
  parameter int ADDRWIDTH    = BUFFER_NUM * ADDR_LEN
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [ADDR_LEN*X_MAC-1:0] st_addr,
  input  logic [MAX_LINE_LEN-1:0]   linelen,
  input  logic                      ispad,
  input  logic [MESH_SEL_LEN-1:0]   mesh_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_LEN*X_MAC-1:0] in_data,
  output logic [ADDRWIDTH-1:0]      addra,
  output logic [DATAWIDTH-1:0]      dina,
  output logic [BUFFER_NUM-1:0]     wea,
  output logic                      line_done,
  output logic                      idle_soon,
  output logic                      addr_err
);

  localparam logic [ADDR_LEN-1:0]     c_ADDR_ONE = ADDR_LEN'(1);
  localparam logic [MAX_LINE_LEN-1:0] c_LEN_ONE  = MAX_LINE_LEN'(1);
  localparam logic [MAX_LINE_LEN-1:0] c_SOON     = MAX_LINE_LEN'(16);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PAD_HEAD = 3'd1,
    S_STREAM   = 3'd2,
    S_PAD_TAIL = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [ADDR_LEN-1:0]     r_col_addr [X_MAC];
  logic [ADDR_LEN-1:0]     r_addr_q   [X_MAC];
  logic [DATA_LEN-1:0]     r_data_q   [X_MAC];
  logic [MESH_SEL_LEN-1:0] r_mesh_sel;
  logic                    r_ispad;
  logic [MAX_LINE_LEN-1:0] r_words_left;
  logic [MAX_LINE_LEN-1:0] w_words_dec;
  logic [MAX_LINE_LEN-1:0] w_pad_reserve;
  logic [BUFFER_NUM-1:0]   r_wea;
  logic                    w_cfg_acc;
  logic                    w_write;
  logic                    w_write_zero;

  assign cfg_ready     = (r_state == S_IDLE);
  assign in_ready      = (r_state == S_STREAM);
  assign w_cfg_acc     = cfg_valid && cfg_ready;
  assign w_words_dec   = r_words_left - c_LEN_ONE;
  assign w_pad_reserve = {{(MAX_LINE_LEN-1){1'b0}}, r_ispad};
  assign line_done     = (r_state == S_DONE);
  assign idle_soon     = (r_state == S_IDLE) || (r_words_left < c_SOON);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_write      = 1'b0;
    w_write_zero = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cfg_acc) begin
          if (linelen == '0)  w_state_nxt = S_DONE;
          else if (ispad)     w_state_nxt = S_PAD_HEAD;
          else                w_state_nxt = S_STREAM;
        end
      end
      S_PAD_HEAD: begin
        w_write      = 1'b1;
        w_write_zero = 1'b1;
        if (w_words_dec == c_LEN_ONE) w_state_nxt = S_PAD_TAIL;
        else if (w_words_dec == '0)   w_state_nxt = S_DONE;
        else                          w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (in_valid) begin
          w_write = 1'b1;
          // Leave the loop once only the tail pad (if any) is still owed.
          if (w_words_dec == w_pad_reserve) begin
            w_state_nxt = r_ispad ? S_PAD_TAIL : S_DONE;
          end
        end
      end
      S_PAD_TAIL: begin
        w_write      = 1'b1;
        w_write_zero = 1'b1;
        w_state_nxt  = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mesh_sel   <= '0;
      r_ispad      <= 1'b0;
      r_words_left <= '0;
      r_wea        <= '0;
      for (int j = 0; j < X_MAC; j++) begin
        r_col_addr[j] <= '0;
        r_addr_q[j]   <= '0;
        r_data_q[j]   <= '0;
      end
    end else begin
      if (w_cfg_acc) begin
        r_mesh_sel   <= mesh_sel;
        r_ispad      <= ispad;
        r_words_left <= linelen;
        for (int j = 0; j < X_MAC; j++) begin
          r_col_addr[j] <= st_addr[j*ADDR_LEN +: ADDR_LEN];
        end
      end else if (w_write) begin
        r_words_left <= w_words_dec;
        for (int j = 0; j < X_MAC; j++) begin
          r_col_addr[j] <= r_col_addr[j] + c_ADDR_ONE;
        end
      end

      r_wea <= '0;
      if (w_write) begin
        r_wea[r_mesh_sel*X_MAC +: X_MAC] <= '1;
        for (int j = 0; j < X_MAC; j++) begin
          r_addr_q[j] <= r_col_addr[j];
          r_data_q[j] <= w_write_zero ? '0 : in_data[j*DATA_LEN +: DATA_LEN];
        end
      end
    end
  end

  // Every row sees the same column address/data; only wea selects the row.
  generate
    for (genvar i = 0; i < X_MESH; i++) begin : g_row
      for (genvar j = 0; j < X_MAC; j++) begin : g_col
        assign addra[(i*X_MAC+j)*ADDR_LEN +: ADDR_LEN] = r_addr_q[j];
        assign dina[(i*X_MAC+j)*DATA_LEN +: DATA_LEN]  = r_data_q[j];
      end
    end
  endgenerate

  assign wea = r_wea;

`ifdef INLINEWRITE_ADDR_CHECK_EN
  logic r_addr_err;
  logic w_at_top;

  always_comb begin
    w_at_top = 1'b0;
    for (int j = 0; j < X_MAC; j++) begin
      if (r_col_addr[j] == '1) w_at_top = 1'b1;
    end
  end

  // A wrap only matters if another write of this line still follows it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_err <= 1'b0;
    end else if (w_write && w_at_top && (w_words_dec != '0)) begin
      r_addr_err <= 1'b1;
    end
  end

  assign addr_err = r_addr_err;
`else
  assign addr_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inlinewrite_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_inlinewrite_control                                                     |
// | Randomized line writes compared against an expected write list.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_inlinewrite_control;

  localparam int X_MAC        = 4;
  localparam int X_MESH       = 16;
  localparam int ADDR_LEN     = 13;
  localparam int DATA_LEN     = 32;
  localparam int MAX_LINE_LEN = 10;
  localparam int MESH_SEL_LEN = 4;
  localparam int BUFFER_NUM   = X_MAC * X_MESH;
  localparam int DATAWIDTH    = BUFFER_NUM * DATA_LEN;
  localparam int ADDRWIDTH    = BUFFER_NUM * ADDR_LEN;
  localparam int AW           = ADDR_LEN * X_MAC;
  localparam int DW           = DATA_LEN * X_MAC;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    cfg_valid = 1'b0;
  logic                    cfg_ready;
  logic [AW-1:0]           st_addr = '0;
  logic [MAX_LINE_LEN-1:0] linelen = '0;
  logic                    ispad = 1'b0;
  logic [MESH_SEL_LEN-1:0] mesh_sel = '0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [DW-1:0]           in_data = '0;
  logic [ADDRWIDTH-1:0]    addra;
  logic [DATAWIDTH-1:0]    dina;
  logic [BUFFER_NUM-1:0]   wea;
  logic                    line_done;
  logic                    idle_soon;
  logic                    addr_err;

  always #5 clk = ~clk;

  inlinewrite_control dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .st_addr   (st_addr),
    .linelen   (linelen),
    .ispad     (ispad),
    .mesh_sel  (mesh_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .addra     (addra),
    .dina      (dina),
    .wea       (wea),
    .line_done (line_done),
    .idle_soon (idle_soon),
    .addr_err  (addr_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: collects the selected row's writes, notes line_done timing.
  logic [AW-1:0]         obs_addr [$];
  logic [DW-1:0]         obs_data [$];
  logic [BUFFER_NUM-1:0] exp_mask = '0;
  int                    cur_sel = 0;
  int                    ncyc = 0;
  int                    done_cnt = 0;
  int                    done_n = 0;
  int                    last_wea_n = 0;
  logic [AW-1:0]         mon_a;
  logic [DW-1:0]         mon_d;

  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (wea != '0) begin
      check_eq("wea_mask", wea, exp_mask);
      for (int j = 0; j < X_MAC; j++) begin
        mon_a[j*ADDR_LEN +: ADDR_LEN] = addra[(cur_sel*X_MAC+j)*ADDR_LEN +: ADDR_LEN];
        mon_d[j*DATA_LEN +: DATA_LEN] = dina[(cur_sel*X_MAC+j)*DATA_LEN +: DATA_LEN];
      end
      obs_addr.push_back(mon_a);
      obs_data.push_back(mon_d);
      last_wea_n = ncyc;
    end
    if (line_done) begin
      done_cnt = done_cnt + 1;
      done_n   = ncyc;
    end
  end

  bit exp_err = 1'b0;

  // mode: 0 back-to-back, 1 valid toggling, 2 random valid
  task automatic run_line(input logic [AW-1:0] st, input int len, input bit pad,
                          input int sel, input int mode);
    int            need;
    int            bi;
    int            n;
    int            acc_n;
    int            done0;
    int            nw;
    int            di;
    bit            acc;
    bit            v;
    logic [DW-1:0] beats [$];
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    need = pad ? ((len > 2) ? len - 2 : 0) : len;
    for (int k = 0; k < need; k++) beats.push_back({$urandom, $urandom, $urandom, $urandom});
`ifdef INLINEWRITE_ADDR_CHECK_EN
    for (int k = 0; k < len - 1; k++)
      for (int j = 0; j < X_MAC; j++)
        if (((int'(st[j*ADDR_LEN +: ADDR_LEN]) + k) % 8192) == 8191) exp_err = 1'b1;
`endif
    obs_addr.delete();
    obs_data.delete();
    cur_sel  = sel;
    exp_mask = '0;
    exp_mask[sel*X_MAC +: X_MAC] = '1;
    done0 = done_cnt;

    check_eq("cfg_ready_idle", cfg_ready, 1'b1);
    check_eq("idle_soon_idle", idle_soon, 1'b1);
    cfg_valid = 1'b1;
    st_addr   = st;
    linelen   = MAX_LINE_LEN'(len);
    ispad     = pad;
    mesh_sel  = MESH_SEL_LEN'(sel);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    acc_n = ncyc;
    check_eq("cfg_ready_busy", cfg_ready, 1'b0);
    check_eq("idle_soon_start", idle_soon, (len < 16));

    bi = 0;
    n  = 0;
    while (done_cnt == done0 && n < 400) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (n % 2 == 0);
        default: v = ($urandom_range(0, 1) == 1);
      endcase
      in_valid = v;
      in_data  = (bi < need) ? beats[bi] : {$urandom, $urandom, $urandom, $urandom};
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      n++;
      if (acc) bi++;
    end
    in_valid = 1'b0;
    if (n >= 400) check_eq("line_timeout", 1'b0, 1'b1);

    check_eq("beats_consumed", bi, need);
    check_eq("write_count", obs_addr.size(), len);
    nw = (obs_addr.size() < len) ? obs_addr.size() : len;
    for (int k = 0; k < nw; k++) begin
      for (int j = 0; j < X_MAC; j++)
        ea[j*ADDR_LEN +: ADDR_LEN] = ADDR_LEN'(int'(st[j*ADDR_LEN +: ADDR_LEN]) + k);
      di = pad ? k - 1 : k;
      if (pad && (k == 0 || k == len - 1)) ed = '0;
      else                                 ed = beats[di];
      check_eq("write_addr", obs_addr[k], ea);
      check_eq("write_data", obs_data[k], ed);
    end
    check_eq("line_done_pulses", done_cnt - done0, 1);
    if (len > 0) check_eq("line_done_timing", done_n, last_wea_n);
    else         check_eq("line_done_timing", done_n, acc_n + 1);
    check_eq("wea_after_line", wea, '0);
    check_eq("line_done_low", line_done, 1'b0);
    check_eq("addr_err", addr_err, exp_err);
  endtask

  initial begin
    int bi;
    int n;
    bit acc;
    logic [AW-1:0] st;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_wea", wea, '0);
    check_eq("rst_addra", addra, '0);
    check_eq("rst_dina", dina, '0);
    check_eq("rst_line_done", line_done, 1'b0);
    check_eq("rst_addr_err", addr_err, 1'b0);
    check_eq("rst_cfg_ready", cfg_ready, 1'b1);
    check_eq("rst_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_line({13'd300, 13'd200, 13'd100, 13'd0}, 4, 1'b0, 2, 0);
    run_line({13'd30, 13'd20, 13'd10, 13'd500}, 6, 1'b1, 5, 0);
    run_line({13'd7, 13'd6, 13'd5, 13'd4}, 8, 1'b0, 9, 1);
    run_line({13'd1, 13'd2, 13'd3, 13'd4}, 0, 1'b0, 3, 0);
    run_line({13'd40, 13'd41, 13'd42, 13'd43}, 2, 1'b1, 15, 0);
    run_line({13'd50, 13'd51, 13'd52, 13'd53}, 1, 1'b1, 0, 0);
    run_line({13'd60, 13'd61, 13'd62, 13'd63}, 1, 1'b0, 7, 0);
    run_line({13'd900, 13'd800, 13'd700, 13'd600}, 40, 1'b1, 11, 2);

    for (int t = 0; t < 12; t++) begin
      for (int j = 0; j < X_MAC; j++) st[j*ADDR_LEN +: ADDR_LEN] = ADDR_LEN'($urandom_range(0, 8000));
      run_line(st, $urandom_range(0, 40), 1'($urandom_range(0, 1)),
               $urandom_range(0, X_MESH - 1), $urandom_range(0, 2));
    end

    run_line({13'd8190, 13'd8190, 13'd8190, 13'd8190}, 4, 1'b0, 4, 0);

    // Reset in the middle of a line, then a clean line.
    cur_sel  = 6;
    exp_mask = '0;
    exp_mask[6*X_MAC +: X_MAC] = '1;
    cfg_valid = 1'b1;
    st_addr   = {13'd1000, 13'd2000, 13'd3000, 13'd4000};
    linelen   = 10'd8;
    ispad     = 1'b0;
    mesh_sel  = 4'd6;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    bi = 0;
    n  = 0;
    while (bi < 3 && n < 50) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      acc = in_ready;
      @(posedge clk); #1;
      n++;
      if (acc) bi++;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_wea", wea, '0);
    check_eq("midrst_cfg_ready", cfg_ready, 1'b1);
    check_eq("midrst_addra", addra, '0);
    check_eq("midrst_addr_err", addr_err, 1'b0);
    exp_err = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_wea", wea, '0);
    run_line({13'd77, 13'd66, 13'd55, 13'd44}, 5, 1'b1, 13, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
